// File: rtl/elevator_scheduler.sv
// Collective (SCAN) car controller for an N-floor elevator.
// Reads latched hall/car requests; drives floor, status and direction.
module elevator_scheduler #(
   parameter int NUM_FLOORS  = 8,
   parameter int FLOOR_W     = 3,
   parameter int MOVE_CYCLES = 50,
   parameter int DOOR_CYCLES = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] upcall,
   input  logic [NUM_FLOORS-1:0] downcall,
   input  logic [NUM_FLOORS-1:0] floor_btn,
   input  logic                  door_hold,
   output logic [FLOOR_W-1:0]    floor,
   output logic [3:0]            status,
   output logic                  dir_up
);

   localparam int MCW = $clog2(MOVE_CYCLES);
   localparam int DCW = $clog2(DOOR_CYCLES);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_UP    = 4'd1,
      S_DOWN  = 4'd2,
      S_OPEN  = 4'd7,
      S_CLOSE = 4'd8
   } state_t;

   state_t           state, state_n;
   logic [FLOOR_W-1:0] floor_n;
   logic             dir_n;
   logic [MCW-1:0]   move_cnt, move_n;
   logic [DCW-1:0]   door_cnt, door_n;

   logic [NUM_FLOORS-1:0] req_all;
   logic [FLOOR_W-1:0]    nf_up, nf_dn;
   logic                  ab, bl, ab_nf, bl_nf;
   state_t                dec_st;
   logic                  dec_dir;

   function automatic logic any_above(
      input logic [NUM_FLOORS-1:0] r,
      input int                    f
   );
      logic a;
      a = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i > f) a = a | r[i];
      return a;
   endfunction

   function automatic logic any_below(
      input logic [NUM_FLOORS-1:0] r,
      input int                    f
   );
      logic b;
      b = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i < f) b = b | r[i];
      return b;
   endfunction

   assign req_all = upcall | downcall | floor_btn;
   assign nf_up   = floor + 1'b1;
   assign nf_dn   = floor - 1'b1;
   assign ab      = any_above(req_all, int'(floor));
   assign bl      = any_below(req_all, int'(floor));
   assign ab_nf   = any_above(req_all, int'(nf_up));
   assign bl_nf   = any_below(req_all, int'(nf_dn));
   assign status  = state;

   // Keep the current sweep while work lies ahead, otherwise reverse.
   always_comb begin
      dec_st  = S_IDLE;
      dec_dir = dir_up;
      if (dir_up && ab) begin
         dec_st = S_UP;
      end else if (!dir_up && bl) begin
         dec_st = S_DOWN;
      end else if (ab) begin
         dec_st  = S_UP;
         dec_dir = 1'b1;
      end else if (bl) begin
         dec_st  = S_DOWN;
         dec_dir = 1'b0;
      end else if (req_all[floor]) begin
         dec_st = S_OPEN;
      end
   end

   always_comb begin
      state_n = state;
      floor_n = floor;
      dir_n   = dir_up;
      move_n  = '0;
      door_n  = '0;
      unique case (state)
         S_IDLE: begin
            if (req_all[floor]) begin
               state_n = S_OPEN;
            end else begin
               state_n = dec_st;
               dir_n   = dec_dir;
            end
         end
         S_UP: begin
            if (move_cnt != MCW'(MOVE_CYCLES - 1)) begin
               move_n = move_cnt + 1'b1;
            end else begin
               floor_n = nf_up;
               if (floor_btn[nf_up] | upcall[nf_up] |
                   (downcall[nf_up] & ~ab_nf)) begin
                  state_n = S_OPEN;
                  dir_n   = ab_nf;
               end else if (!ab_nf) begin
                  state_n = S_IDLE;
               end
            end
         end
         S_DOWN: begin
            if (move_cnt != MCW'(MOVE_CYCLES - 1)) begin
               move_n = move_cnt + 1'b1;
            end else begin
               floor_n = nf_dn;
               if (floor_btn[nf_dn] | downcall[nf_dn] |
                   (upcall[nf_dn] & ~bl_nf)) begin
                  state_n = S_OPEN;
                  dir_n   = ~bl_nf;
               end else if (!bl_nf) begin
                  state_n = S_IDLE;
               end
            end
         end
         S_OPEN: begin
            if (door_hold) begin
               door_n = '0;
            end else if (door_cnt == DCW'(DOOR_CYCLES - 1)) begin
               state_n = S_CLOSE;
            end else begin
               door_n = door_cnt + 1'b1;
            end
         end
         S_CLOSE: begin
            state_n = dec_st;
            dir_n   = dec_dir;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         floor    <= '0;
         dir_up   <= 1'b1;
         move_cnt <= '0;
         door_cnt <= '0;
      end else begin
         state    <= state_n;
         floor    <= floor_n;
         dir_up   <= dir_n;
         move_cnt <= move_n;
         door_cnt <= door_n;
      end
   end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler (MOVE_CYCLES=4, DOOR_CYCLES=6).
// Acts as the request buffer: clears the current floor's requests while OPEN.
module tb_elevator_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] upcall, downcall, floor_btn;
   logic       door_hold;
   logic [2:0] floor;
   logic [3:0] status;
   logic       dir_up;

   int tests = 0;
   int fails = 0;

   elevator_scheduler #(
      .NUM_FLOORS (8),
      .FLOOR_W    (3),
      .MOVE_CYCLES(4),
      .DOOR_CYCLES(6)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .upcall   (upcall),
      .downcall (downcall),
      .floor_btn(floor_btn),
      .door_hold(door_hold),
      .floor    (floor),
      .status   (status),
      .dir_up   (dir_up)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (status == 4'd7) begin
         upcall[floor]    = 1'b0;
         downcall[floor]  = 1'b0;
         floor_btn[floor] = 1'b0;
      end
   endtask

   task automatic wait_st(input logic [3:0] s, input string tag);
      int n;
      n = 0;
      while (status !== s && n < 60) begin
         tick();
         n++;
      end
      chk(tag, 32'(status), 32'(s));
   endtask

   task automatic pulse_rst();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      upcall    = '0;
      downcall  = '0;
      floor_btn = '0;
      door_hold = 1'b0;

      // 1: reset state, idle with no requests
      #23;
      chk("rst_floor", 32'(floor), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_dir", 32'(dir_up), 32'd1);
      rst = 1'b1;
      repeat (3) tick();
      chk("idle_status", 32'(status), 32'd0);
      chk("idle_floor", 32'(floor), 32'd0);

      // 2: car call to floor 3
      floor_btn = 8'b0000_1000;
      tick();
      chk("t2_up", 32'(status), 32'd1);
      repeat (3) tick();
      chk("t2_f0", 32'(floor), 32'd0);
      tick();
      chk("t2_f1", 32'(floor), 32'd1);
      chk("t2_f1_st", 32'(status), 32'd1);
      repeat (4) tick();
      chk("t2_f2", 32'(floor), 32'd2);
      repeat (4) tick();
      chk("t2_f3", 32'(floor), 32'd3);
      chk("t2_open", 32'(status), 32'd7);
      chk("t2_dir", 32'(dir_up), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_open_hold", 32'(status), 32'd7);
      end
      tick();
      chk("t2_close", 32'(status), 32'd8);
      tick();
      chk("t2_idle", 32'(status), 32'd0);

      // 3: sweep up with hall calls, then reverse
      pulse_rst();
      floor_btn = 8'b0010_0000;
      upcall    = 8'b0000_0100;
      downcall  = 8'b0000_1000;
      wait_st(4'd7, "t3_open2");
      chk("t3_f2", 32'(floor), 32'd2);
      chk("t3_dir2", 32'(dir_up), 32'd1);
      wait_st(4'd8, "t3_close2");
      wait_st(4'd7, "t3_open5");
      chk("t3_f5", 32'(floor), 32'd5);
      chk("t3_dir5", 32'(dir_up), 32'd0);
      wait_st(4'd2, "t3_down");
      chk("t3_down_dir", 32'(dir_up), 32'd0);
      wait_st(4'd7, "t3_open3");
      chk("t3_f3", 32'(floor), 32'd3);
      wait_st(4'd0, "t3_idle");

      // 4: hall call at the idle floor opens immediately
      floor_btn = 8'b0001_0000;
      wait_st(4'd7, "t4_go4");
      chk("t4_at4", 32'(floor), 32'd4);
      wait_st(4'd0, "t4_idle4");
      downcall = 8'b0001_0000;
      tick();
      chk("t4_open", 32'(status), 32'd7);
      chk("t4_floor", 32'(floor), 32'd4);

      // 5: door hold extends the open time
      door_hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t5_held", 32'(status), 32'd7);
      end
      door_hold = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_tail", 32'(status), 32'd7);
      end
      tick();
      chk("t5_close", 32'(status), 32'd8);
      tick();
      chk("t5_idle", 32'(status), 32'd0);

      // 6: asynchronous reset while moving
      pulse_rst();
      floor_btn = 8'b0100_0000;
      tick();
      repeat (10) tick();
      chk("t6_moving", 32'(status), 32'd1);
      chk("t6_at2", 32'(floor), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_floor", 32'(floor), 32'd0);
      chk("t6_status", 32'(status), 32'd0);
      chk("t6_dir", 32'(dir_up), 32'd1);
      repeat (2) tick();
      chk("t6_hold_st", 32'(status), 32'd0);
      chk("t6_hold_fl", 32'(floor), 32'd0);
      rst = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
